// File: rtl/ram_host_arbiter.sv
// Shares the agc_ram erasable port between the Core (default owner) and a host
// requester; a host access stalls the Core, then restores the Core read address.
module ram_host_arbiter #(
  parameter int RD_LAT   = 1,
  parameter int CORE_MIN = 4,
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 15
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] core_rd_addr,
  input  logic [ADDR_W-1:0] core_wr_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  input  logic              core_wr_en,
  input  logic              core_stall,
  output logic              arb_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_wr_en,
  output logic              ram_addr_stall,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int               GAP_W    = (CORE_MIN > 0) ? $clog2(CORE_MIN + 1) : 1;
  localparam logic [1:0]       LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(CORE_MIN);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    ST_CORE,
    ST_ACCESS,
    ST_WAIT,
    ST_RESTORE
  } state_t;

  state_t            state_q, state_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  // Shared by WAIT (read latency) and RESTORE (Core re-read latency).
  logic [1:0]        lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_CORE;
      gap_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    lat_cnt_d      = lat_cnt_q;
    host_rdata_d   = host_rdata_q;
    arb_stall      = 1'b1;
    host_ack       = 1'b0;
    ram_rd_addr    = core_rd_addr;
    ram_wr_addr    = core_wr_addr;
    ram_wr_data    = core_wr_data;
    ram_wr_en      = 1'b0;
    ram_addr_stall = 1'b0;

    unique case (state_q)
      ST_CORE: begin
        arb_stall      = 1'b0;
        ram_wr_en      = core_wr_en;
        ram_addr_stall = core_stall;
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_ONE;
        end else if (host_req) begin
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        ram_rd_addr = host_addr;
        ram_wr_addr = host_addr;
        ram_wr_data = host_wdata;
        ram_wr_en   = host_we;
        lat_cnt_d   = LAT_LAST;
        state_d     = host_we ? ST_RESTORE : ST_WAIT;
      end
      ST_WAIT: begin
        ram_rd_addr = host_addr;
        if (lat_cnt_q == 2'd0) begin
          host_rdata_d = ram_q;
          lat_cnt_d    = LAT_LAST;
          state_d      = ST_RESTORE;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      ST_RESTORE: begin
        // Core read address is back on the RAM; its data lands as the stall drops.
        host_ack = (lat_cnt_q == LAT_LAST);
        if (lat_cnt_q == 2'd0) begin
          state_d   = ST_CORE;
          gap_cnt_d = GAP_INIT;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = ST_CORE;
      end
    endcase
  end

  assign host_rdata = host_rdata_q;

endmodule
